// File: rtl/staggered_reset_driver.sv
// staggered_reset_driver
//
// Multi-channel reset sequencer. A start request in IDLE asserts all
// NUM_CHANNELS reset outputs for ASSERT_CYCLES cycles. The channels are then
// released either all together (mode = 0) or one at a time in ascending index
// order, STAGGER_CYCLES apart (mode = 1). A one-cycle done pulse marks the end
// of the sequence. Abort restarts the assert phase while a sequence is busy.
//
// Ports:
//   clk        rising-edge clock for all logic
//   reset      synchronous active-high reset
//   start      sequence request, sampled only in IDLE
//   mode       0 = simultaneous release, 1 = staggered; latched when start is accepted
//   abort      restart the assert phase, honoured only while busy
//   reset_out  per-channel active-high reset outputs (registered)
//   busy       sequence in progress (registered)
//   done       one-cycle completion pulse (registered)

module staggered_reset_driver #(
    parameter int NUM_CHANNELS   = 4,
    parameter int ASSERT_CYCLES  = 16,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic                    abort,
    output logic [NUM_CHANNELS-1:0] reset_out,
    output logic                    busy,
    output logic                    done
);

    localparam int MAX_CYCLES = (ASSERT_CYCLES > STAGGER_CYCLES) ? ASSERT_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam int IDX_W      = $clog2(NUM_CHANNELS) + 1;

    localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state,        state_nx;
    logic [CNT_W-1:0]        cnt,          cnt_nx;
    logic [IDX_W-1:0]        idx,          idx_nx;
    logic                    mode_q,       mode_nx;
    logic [NUM_CHANNELS-1:0] reset_out_nx;
    logic                    busy_nx;
    logic                    done_nx;

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            mode_q    <= 1'b0;
            reset_out <= '1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            mode_q    <= mode_nx;
            reset_out <= reset_out_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    // Next-state and next-output logic. Abort is checked before any release
    // so that an abort landing on a release edge leaves every bit asserted.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        idx_nx       = idx;
        mode_nx      = mode_q;
        reset_out_nx = reset_out;
        busy_nx      = busy;
        done_nx      = 1'b0;

        unique case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (start) begin
                    state_nx     = ASSERT;
                    cnt_nx       = '0;
                    idx_nx       = '0;
                    mode_nx      = mode;
                    reset_out_nx = '1;
                    busy_nx      = 1'b1;
                end
            end

            ASSERT: begin
                if (abort) begin
                    cnt_nx       = '0;
                    idx_nx       = '0;
                    reset_out_nx = '1;
                end else if (cnt == ASSERT_LAST) begin
                    // A single-channel staggered run has nothing left to stagger.
                    if (!mode_q || NUM_CHANNELS == 1) begin
                        reset_out_nx = '0;
                        state_nx     = DONE;
                        busy_nx      = 1'b0;
                        done_nx      = 1'b1;
                    end else begin
                        reset_out_nx[0] = 1'b0;
                        cnt_nx          = '0;
                        idx_nx          = IDX_W'(1);
                        state_nx        = RELEASE;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end

            RELEASE: begin
                if (abort) begin
                    cnt_nx       = '0;
                    idx_nx       = '0;
                    reset_out_nx = '1;
                    state_nx     = ASSERT;
                end else if (cnt == STAGGER_LAST) begin
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        if (IDX_W'(i) == idx) begin
                            reset_out_nx[i] = 1'b0;
                        end
                    end
                    cnt_nx = '0;
                    idx_nx = idx + IDX_W'(1);
                    if (idx == IDX_LAST) begin
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end

            DONE: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_staggered_reset_driver.sv
// tb_staggered_reset_driver
//
// Drives three builds of staggered_reset_driver (N=4, N=1, N=8) from shared
// inputs and compares every output after every edge against a timeline model:
// channel i is expected released once the edges elapsed since the accepting
// start (or the last abort) reach ASSERT + i*STAGGER (or ASSERT for all
// channels in simultaneous mode).

module tb_staggered_reset_driver;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic abort = 1'b0;

    logic [3:0] ro4;
    logic       busy4, done4;
    logic [0:0] ro1;
    logic       busy1, done1;
    logic [7:0] ro8;
    logic       busy8, done8;

    int checks = 0;
    int failures = 0;
    int edgeNum = 0;

    always #5 clk = ~clk;

    staggered_reset_driver #(.NUM_CHANNELS(4), .ASSERT_CYCLES(3), .STAGGER_CYCLES(2)) dut4 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
        .reset_out(ro4), .busy(busy4), .done(done4));

    staggered_reset_driver #(.NUM_CHANNELS(1), .ASSERT_CYCLES(3), .STAGGER_CYCLES(2)) dut1 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
        .reset_out(ro1), .busy(busy1), .done(done1));

    staggered_reset_driver #(.NUM_CHANNELS(8), .ASSERT_CYCLES(4), .STAGGER_CYCLES(3)) dut8 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
        .reset_out(ro8), .busy(busy8), .done(done8));

    typedef struct {
        bit         running;
        int         elapsed;
        bit         mode;
        bit         busy;
        bit         done;
        logic [7:0] out;
    } model_t;

    model_t m4, m1, m8;

    function automatic logic [7:0] allOnes(int n);
        logic [7:0] o = '0;
        for (int i = 0; i < n; i++) o[i] = 1'b1;
        return o;
    endfunction

    // One clock edge of the reference timeline for a build with n channels.
    function automatic model_t modelStep(model_t m, int n, int a, int s,
                                         bit r, bit st, bit md, bit ab);
        model_t nx = m;
        nx.done = 1'b0;
        if (r) begin
            nx.running = 1'b0;
            nx.busy    = 1'b0;
            nx.out     = allOnes(n);
        end else if (m.running) begin
            if (ab) begin
                nx.elapsed = 0;
                nx.out     = allOnes(n);
                nx.busy    = 1'b1;
            end else begin
                nx.elapsed = m.elapsed + 1;
                for (int i = 0; i < n; i++) begin
                    if (nx.elapsed >= a + (m.mode ? i * s : 0)) nx.out[i] = 1'b0;
                end
                if (nx.elapsed == a + (m.mode ? (n - 1) * s : 0)) begin
                    nx.running = 1'b0;
                    nx.busy    = 1'b0;
                    nx.done    = 1'b1;
                end
            end
        end else if (m.done) begin
            nx.busy = 1'b0;
        end else if (st) begin
            nx.running = 1'b1;
            nx.elapsed = 0;
            nx.mode    = md;
            nx.out     = allOnes(n);
            nx.busy    = 1'b1;
        end
        return nx;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at edge %0d: got %b, expected %b", tag, edgeNum, actual, expected);
        end
    endtask

    // Drive one set of inputs on the falling edge, advance the models, then
    // compare all builds just after the following rising edge.
    task automatic applyStimulus(input bit r, input bit st, input bit md, input bit ab);
        @(negedge clk);
        reset = r;
        start = st;
        mode  = md;
        abort = ab;
        m4 = modelStep(m4, 4, 3, 2, r, st, md, ab);
        m1 = modelStep(m1, 1, 3, 2, r, st, md, ab);
        m8 = modelStep(m8, 8, 4, 3, r, st, md, ab);
        @(posedge clk);
        #1;
        edgeNum++;
        checkOutput("n4_out",  8'(ro4),   m4.out);
        checkOutput("n4_busy", 8'(busy4), 8'(m4.busy));
        checkOutput("n4_done", 8'(done4), 8'(m4.done));
        checkOutput("n1_out",  8'(ro1),   m1.out);
        checkOutput("n1_busy", 8'(busy1), 8'(m1.busy));
        checkOutput("n1_done", 8'(done1), 8'(m1.done));
        checkOutput("n8_out",  ro8,       m8.out);
        checkOutput("n8_busy", 8'(busy8), 8'(m8.busy));
        checkOutput("n8_done", 8'(done8), 8'(m8.done));
    endtask

    logic [3:0] stagTable [1:10];
    int         doneCount;

    initial begin
        m4 = '{running: 1'b0, elapsed: 0, mode: 1'b0, busy: 1'b0, done: 1'b0, out: 8'h0F};
        m1 = '{running: 1'b0, elapsed: 0, mode: 1'b0, busy: 1'b0, done: 1'b0, out: 8'h01};
        m8 = '{running: 1'b0, elapsed: 0, mode: 1'b0, busy: 1'b0, done: 1'b0, out: 8'hFF};
        stagTable = '{4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1100,
                      4'b1100, 4'b1000, 4'b1000, 4'b0000, 4'b0000};

        // Reset for three cycles, then idle for twenty.
        repeat (3) applyStimulus(1, 0, 0, 0);
        checkOutput("reset_out_4", 8'(ro4), 8'h0F);
        repeat (20) applyStimulus(0, 0, 0, 0);
        checkOutput("idle_out_4", 8'(ro4), 8'h0F);

        // Simultaneous release.
        applyStimulus(0, 1, 0, 0);
        repeat (6) applyStimulus(0, 0, 0, 0);
        checkOutput("simul_final_4", 8'(ro4), 8'h00);

        // Abort in IDLE leaves outputs alone.
        repeat (2) applyStimulus(0, 0, 1, 1);

        // Staggered release against a fixed timeline.
        applyStimulus(0, 1, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("stag_table_4", 8'(ro4), 8'(stagTable[k]));
        end
        repeat (3) applyStimulus(0, 0, 0, 0);

        // Abort mid-release at edge 6, ignored start at edge 8.
        applyStimulus(0, 1, 1, 0);
        for (int k = 1; k <= 18; k++) begin
            applyStimulus(0, (k == 8 || k == 3), 0, (k == 6));
        end

        // Start together with abort in IDLE starts normally.
        applyStimulus(0, 1, 1, 1);
        repeat (30) applyStimulus(0, 0, 0, 0);

        // Reset at edge 6 of a staggered run.
        applyStimulus(0, 1, 1, 0);
        repeat (5) applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("midreset_out_4", 8'(ro4), 8'h0F);
        repeat (5) applyStimulus(0, 0, 0, 0);

        // Start held high: back-to-back sequences.
        doneCount = 0;
        repeat (60) begin
            applyStimulus(0, 1, 1, 0);
            if (done4) doneCount++;
        end
        checkOutput("b2b_done_count_4", 8'(doneCount >= 2), 8'd1);
        repeat (40) applyStimulus(0, 0, 0, 0);

        // Randomized traffic.
        repeat (3000) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 99) < 30,
                          1'($urandom_range(0, 1)),
                          $urandom_range(0, 99) < 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/staggered_reset_driver.md
Name: staggered_reset_driver

Overview:
Parametrised multi-channel reset sequencer used by the conduit-adapter simulation and test systems. It replaces the fixed single-pulse stimulus driver. On a start request it holds NUM_CHANNELS active-high reset outputs asserted for a programmable time. It then releases the channels either all at once or staggered in index order, and signals completion with busy/done status. It is synthesizable, so the same block can sit in hardware test systems.

Parameters:
NUM_CHANNELS, 4, number of reset outputs; legal range is 1 or more.
ASSERT_CYCLES, 16, cycles all outputs stay asserted before the first release; legal range is 1 or more.
STAGGER_CYCLES, 8, cycles between successive channel releases in staggered mode; legal range is 1 or more.

Ports:
clk  input  1  single clock; all logic is on its rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a sequence; sampled only in IDLE.
mode  input  1  0 = simultaneous release, 1 = staggered release; captured on the edge that accepts start.
abort  input  1  restart the assert phase; honoured only while busy.
reset_out  output  NUM_CHANNELS  per-channel active-high reset.
busy  output  1  sequence in progress.
done  output  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered. Internal counters are sized internally to clog2 of max(ASSERT_CYCLES, STAGGER_CYCLES) plus 1.
- Reset:
  - state = IDLE, reset_out = all ones, busy = 0, done = 0, counter = 0, channel index = 0.
  - Reset overrides start and abort, and aborts any sequence in progress.
- State machine (IDLE, ASSERT, RELEASE, DONE), with edge T = the edge that accepts start:
  - IDLE: reset_out holds its last value (all ones after reset, all zeros after a completed sequence). done = 0.
  - IDLE with start = 1 at edge T:
    - next state ASSERT, reset_out = all ones, counter = 0, busy = 1.
    - mode is latched into mode_q.
  - ASSERT:
    - counter increments each edge.
    - On the edge where the pre-increment counter equals ASSERT_CYCLES-1 (edge T+ASSERT_CYCLES), the first release occurs.
    - mode_q = 0: all bits cleared, go to DONE.
    - mode_q = 1: bit 0 cleared, counter = 0, index = 1, go to RELEASE. If NUM_CHANNELS = 1, go to DONE instead.
  - RELEASE:
    - counter increments each edge.
    - When the counter equals STAGGER_CYCLES-1: clear bit[index], counter = 0, index increments.
    - The edge that clears bit NUM_CHANNELS-1 goes to DONE.
    - Result: channel i deasserts at edge T+ASSERT_CYCLES+i*STAGGER_CYCLES.
    - Channels release strictly in ascending index order, and a released bit never reasserts except on abort or reset.
  - DONE: lasts exactly one cycle, with done = 1 and busy = 0 (busy clears on the same edge that enters DONE). The next edge goes to IDLE, done = 0.
- start handling:
  - start while busy or in DONE is ignored (not queued).
  - start held high continuously re-triggers at the first IDLE cycle, so sequences run back-to-back with one IDLE cycle between them.
- abort handling:
  - abort = 1 in ASSERT or RELEASE: reset_out = all ones, counter = 0, index = 0, state ASSERT, busy stays 1, mode_q is unchanged.
  - That abort edge becomes the new T.
  - abort in IDLE or DONE is ignored.
- Simultaneous events:
  - start and abort together in IDLE: start is accepted and abort is ignored.
  - abort on the same edge a release would occur: abort wins and no bit clears.

Test Plan:
- Reset then idle: assert reset 3 cycles with start = 0 -> reset_out = 4'b1111, busy = 0, done = 0. All stay unchanged for 20 cycles after reset drops.
- Simultaneous release (ASSERT=3, N=4): start with mode = 0 at edge 0 -> busy = 1 from edge 0. reset_out = 1111 until edge 3, then 0000. done = 1 only in the cycle after edge 3, and busy = 0 from edge 3.
- Staggered release (ASSERT=3, STAGGER=2, N=4): mode = 1 at edge 0 -> reset_out goes 1110 @3, 1100 @5, 1000 @7, 0000 @9. done pulses in the cycle after edge 9, then IDLE.
- Abort mid-release (same parameters): abort at edge 6 -> reset_out = 1111 at edge 6. Re-release follows: 1110 @9, 1100 @11, 1000 @13, 0000 @15. A start pulse at edge 8 has no effect.
- Ignored and simultaneous inputs:
  - start pulses during busy: no extra done pulses.
  - start + abort together in IDLE: the sequence starts normally.
  - abort in IDLE: reset_out is unchanged.
- Reset mid-operation and back-to-back: reset at edge 6 of a staggered run -> reset_out = 1111, busy = 0, no done pulse. With start held high, two full sequences complete separated by exactly one IDLE cycle. Run N=1 and N=8 builds for the parameter edge cases.
